// File: rtl/exmem_stream_reader.sv
// exmem_stream_reader
// Reads cfg_len consecutive 32-bit words from a Wishbone slave window and
// forwards them on an AXI-Stream port toward the FIR. A small FIFO decouples
// the bus from the stream; a read is issued only when a FIFO slot is free, so
// the FIFO can never overflow. A read that is not acknowledged within TIMEOUT
// cycles aborts the transfer and sets the sticky err flag.
//
// Ports
//   wb_clk_i, wb_rst_n         clock, async active-low reset
//   cfg_start/base_addr/len    one-cycle start, first byte address (0 -> BASE_ADDR), word count
//   busy, done, err            status: in progress, one-cycle completion, sticky timeout
//   wbm_*                      Wishbone master (read only, single outstanding read)
//   ss_t*                      AXI-Stream sample output
module exmem_stream_reader #(
  parameter logic [31:0] BASE_ADDR  = 32'h3800_0000,
  parameter int          FIFO_DEPTH = 4,
  parameter int          TIMEOUT    = 31
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n,
  input  logic        cfg_start,
  input  logic [31:0] cfg_base_addr,
  input  logic [15:0] cfg_len,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  output logic [31:0] ss_tdata,
  output logic        ss_tvalid,
  input  logic        ss_tready,
  output logic        ss_tlast
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_DRAIN = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  state_t        r_state, w_next;
  logic          r_busy, r_done, r_err, r_cyc;
  logic [31:0]   r_adr, r_base;
  logic [15:0]   r_len, r_idx;
  logic [TW-1:0] r_wcnt;

  // FIFO entry: {tlast, data}
  logic [32:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_cnt;

  logic          w_start, w_issue, w_ack, w_tmo;
  logic          w_more, w_space, w_rd;
  logic [32:0]   w_head;

  // 17-bit compare so idx+1 cannot wrap when len = 16'hFFFF
  assign w_more  = ({1'b0, r_idx} + 17'd1) < {1'b0, r_len};
  assign w_space = r_cnt < CW'(FIFO_DEPTH);
  assign w_head  = r_mem[r_rp];
  assign w_rd    = ss_tvalid & ss_tready;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) r_state <= S_IDLE;
    else           r_state <= w_next;
  end

  // ---------------- FSM: next state / control ----------------
  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    w_issue = 1'b0;
    w_ack   = 1'b0;
    w_tmo   = 1'b0;
    case (r_state)
      S_IDLE: begin
        // r_busy is still high during the done cycle; a start there is ignored
        if (cfg_start && !r_busy) begin
          w_start = 1'b1;
          w_next  = (cfg_len == 16'd0) ? S_FIN : S_REQ;
        end
      end
      S_REQ: begin
        if (w_space) begin
          w_issue = 1'b1;
          w_next  = S_WAIT;
        end
      end
      S_WAIT: begin
        // an ack on the last allowed cycle still wins over the timeout
        if (wbm_ack_i) begin
          w_ack  = 1'b1;
          w_next = w_more ? S_REQ : S_DRAIN;
        end else if (r_wcnt == TW'(TIMEOUT - 1)) begin
          w_tmo  = 1'b1;
          w_next = S_DRAIN;
        end
      end
      S_DRAIN: if (r_cnt == '0) w_next = S_FIN;
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // ---------------- control / bus registers ----------------
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
      r_cyc  <= 1'b0;
      r_adr  <= '0;
      r_base <= '0;
      r_len  <= '0;
      r_idx  <= '0;
      r_wcnt <= '0;
    end else begin
      r_done <= (r_state == S_FIN);
      if (w_start)     r_busy <= 1'b1;
      else if (r_done) r_busy <= 1'b0;

      if (w_start)    r_err <= 1'b0;
      else if (w_tmo) r_err <= 1'b1;

      if (w_start) begin
        r_base <= (cfg_base_addr == 32'd0) ? BASE_ADDR : cfg_base_addr;
        r_len  <= cfg_len;
        r_idx  <= '0;
      end else if (w_ack) begin
        r_idx  <= r_idx + 16'd1;
      end

      // address is modulo 2^32 by construction of the 32-bit add
      if (w_issue) begin
        r_cyc <= 1'b1;
        r_adr <= r_base + {14'd0, r_idx, 2'b00};
      end else if (w_ack || w_tmo) begin
        r_cyc <= 1'b0;
      end

      if (w_issue)                           r_wcnt <= '0;
      else if (r_state == S_WAIT && !w_ack)  r_wcnt <= r_wcnt + TW'(1);
    end
  end

  // ---------------- output FIFO ----------------
  always_ff @(posedge wb_clk_i) begin
    if (w_ack) r_mem[r_wp] <= {~w_more, wbm_dat_i};
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_ack) r_wp <= r_wp + AW'(1);
      if (w_rd)  r_rp <= r_rp + AW'(1);
      case ({w_ack, w_rd})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // ---------------- outputs ----------------
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign wbm_cyc_o = r_cyc;
  assign wbm_stb_o = r_cyc;
  assign wbm_we_o  = 1'b0;
  assign wbm_sel_o = 4'hF;
  assign wbm_adr_o = r_adr;

  // FIFO storage is not reset; gate the head so outputs read 0 when empty
  assign ss_tvalid = (r_cnt != '0);
  assign ss_tdata  = ss_tvalid ? w_head[31:0] : 32'd0;
  assign ss_tlast  = ss_tvalid & w_head[32];

endmodule

// File: tb/tb_exmem_stream_reader.sv
// Testbench for exmem_stream_reader: Wishbone slave model with programmable
// ack delay, stream monitor feeding an observed-beat queue, and per-scenario
// tasks comparing against expected queues built when stimulus is driven.
module tb_exmem_stream_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_start;
  logic [31:0] cfg_base_addr;
  logic [15:0] cfg_len;
  logic        busy, done, err;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_i;
  logic        wbm_ack_i;
  logic [31:0] ss_tdata;
  logic        ss_tvalid, ss_tready, ss_tlast;

  always #5 clk = ~clk;

  exmem_stream_reader dut (
    .wb_clk_i(clk), .wb_rst_n(rst_n),
    .cfg_start(cfg_start), .cfg_base_addr(cfg_base_addr), .cfg_len(cfg_len),
    .busy(busy), .done(done), .err(err),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_i(wbm_dat_i),
    .wbm_ack_i(wbm_ack_i),
    .ss_tdata(ss_tdata), .ss_tvalid(ss_tvalid), .ss_tready(ss_tready), .ss_tlast(ss_tlast)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_done = 0, n_ack = 0, n_cyc = 0;
  int ack_delay = 0;
  int slv_wc = 0;
  bit ack_en = 1'b1;

  logic [31:0] adr_log [$];
  logic [31:0] exp_adr [$];
  logic [32:0] obs_q   [$];
  logic [32:0] exp_q   [$];

  // slave read data is a fixed function of the address
  function automatic logic [31:0] slv_data(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'h1234};
  endfunction

  // Wishbone slave: ack for exactly one cycle after ack_delay cycles of cyc&stb
  initial begin
    wbm_ack_i = 1'b0;
    wbm_dat_i = 32'd0;
    forever begin
      @(posedge clk); #1;
      if (wbm_ack_i) begin
        wbm_ack_i = 1'b0;
        slv_wc = 0;
      end else if (wbm_cyc_o && wbm_stb_o && ack_en) begin
        if (slv_wc >= ack_delay) begin
          wbm_ack_i = 1'b1;
          wbm_dat_i = slv_data(wbm_adr_o);
          adr_log.push_back(wbm_adr_o);
          n_ack++;
          slv_wc = 0;
        end else slv_wc++;
      end else slv_wc = 0;
    end
  end

  // beats / done pulses / cyc cycles sampled mid-cycle
  always @(negedge clk) begin
    if (rst_n) begin
      if (ss_tvalid && ss_tready) obs_q.push_back({ss_tlast, ss_tdata});
      if (done) n_done++;
      if (wbm_cyc_o) n_cyc++;
    end
  end

  task automatic clr();
    adr_log.delete(); exp_adr.delete(); obs_q.delete(); exp_q.delete();
    n_done = 0; n_ack = 0; n_cyc = 0;
  endtask

  task automatic push_exp(input logic [31:0] base, input int len);
    logic [31:0] eff, a;
    eff = (base == 32'd0) ? 32'h3800_0000 : base;
    for (int i = 0; i < len; i++) begin
      a = eff + 32'(4 * i);
      exp_adr.push_back(a);
      exp_q.push_back({(i == len - 1), slv_data(a)});
    end
  endtask

  task automatic start(input logic [31:0] base, input logic [15:0] len);
    @(posedge clk); #1;
    cfg_base_addr = base; cfg_len = len; cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_checks++;
    if ({busy, done, err, wbm_cyc_o, wbm_stb_o, ss_tvalid, ss_tlast} !== 7'b0) begin
      n_errors++; $display("FAIL reset_flags: got %b want 0000000",
        {busy, done, err, wbm_cyc_o, wbm_stb_o, ss_tvalid, ss_tlast});
    end
    n_checks++;
    if (wbm_adr_o !== 32'd0 || ss_tdata !== 32'd0) begin
      n_errors++; $display("FAIL reset_buses: got adr=%h tdata=%h want 0", wbm_adr_o, ss_tdata);
    end
    n_checks++;
    if (wbm_we_o !== 1'b0 || wbm_sel_o !== 4'hF) begin
      n_errors++; $display("FAIL reset_we_sel: got we=%b sel=%h want 0/f", wbm_we_o, wbm_sel_o);
    end
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || wbm_cyc_o !== 1'b0) begin
      n_errors++; $display("FAIL reset_release_idle: got busy=%b cyc=%b want 0", busy, wbm_cyc_o);
    end
  endtask

  task automatic test_basic();
    bit ok;
    logic [32:0] e, o;
    clr(); ack_delay = 10; ack_en = 1'b1; ss_tready = 1'b1;
    push_exp(32'h0, 3);
    start(32'h0, 16'd3);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (wbm_ack_i) begin ok = 1'b1; break; end
    end
    n_checks++;
    if (!ok || ss_tvalid !== 1'b0) begin
      n_errors++; $display("FAIL basic_first_ack: got ack_seen=%b tvalid=%b want 1/0", ok, ss_tvalid);
    end
    @(negedge clk);
    n_checks++;
    if (ss_tvalid !== 1'b1) begin
      n_errors++; $display("FAIL basic_latency: got tvalid=%b want 1 one cycle after ack", ss_tvalid);
    end
    wait_done(300, ok);
    n_checks++;
    if (!ok) begin n_errors++; $display("FAIL basic_done_timeout: got no done want done"); end
    repeat (3) @(negedge clk);
    n_checks++;
    if (adr_log.size() != 3) begin
      n_errors++; $display("FAIL basic_nreads: got %0d want 3", adr_log.size());
    end
    foreach (exp_adr[i]) if (i < adr_log.size()) begin
      n_checks++;
      if (adr_log[i] !== exp_adr[i]) begin
        n_errors++; $display("FAIL basic_addr[%0d]: got %h want %h", i, adr_log[i], exp_adr[i]);
      end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_errors++; $display("FAIL basic_beat: got none want %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin n_errors++; $display("FAIL basic_beat: got %h want %h", o, e); end
      end
    end
    n_checks++;
    if (obs_q.size() != 0 || n_done != 1 || err !== 1'b0 || busy !== 1'b0) begin
      n_errors++; $display("FAIL basic_end: got extra=%0d done=%0d err=%b busy=%b want 0/1/0/0",
        obs_q.size(), n_done, err, busy);
    end
  endtask

  task automatic test_backpressure();
    bit ok, seen;
    int unstable;
    logic [32:0] held, e, o;
    clr(); ack_delay = 0; ss_tready = 1'b0;
    push_exp(32'h1000_0000, 8);
    start(32'h1000_0000, 16'd8);
    seen = 1'b0; unstable = 0; held = '0;
    repeat (100) begin
      @(negedge clk);
      if (ss_tvalid) begin
        if (seen && {ss_tlast, ss_tdata} !== held) unstable++;
        held = {ss_tlast, ss_tdata};
        seen = 1'b1;
      end
    end
    n_checks++;
    if (n_ack != 4) begin n_errors++; $display("FAIL bp_acks: got %0d want 4", n_ack); end
    n_checks++;
    if (wbm_cyc_o !== 1'b0) begin n_errors++; $display("FAIL bp_cyc_low: got %b want 0", wbm_cyc_o); end
    n_checks++;
    if (unstable != 0 || held !== exp_q[0]) begin
      n_errors++; $display("FAIL bp_stable: got changes=%0d head=%h want 0/%h", unstable, held, exp_q[0]);
    end
    @(posedge clk); #1; ss_tready = 1'b1;
    wait_done(400, ok);
    n_checks++;
    if (!ok) begin n_errors++; $display("FAIL bp_done_timeout: got no done want done"); end
    repeat (3) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_errors++; $display("FAIL bp_beat: got none want %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin n_errors++; $display("FAIL bp_beat: got %h want %h", o, e); end
      end
    end
    n_checks++;
    if (obs_q.size() != 0 || n_done != 1 || err !== 1'b0) begin
      n_errors++; $display("FAIL bp_end: got extra=%0d done=%0d err=%b want 0/1/0", obs_q.size(), n_done, err);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    clr(); ack_en = 1'b0; ss_tready = 1'b1;
    start(32'h2000_0000, 16'd2);
    wait_done(200, ok);
    n_checks++;
    if (!ok) begin n_errors++; $display("FAIL to_done_timeout: got no done want done"); end
    repeat (3) @(negedge clk);
    n_checks++;
    if (n_cyc != 31) begin n_errors++; $display("FAIL to_cyc_len: got %0d want 31", n_cyc); end
    n_checks++;
    if (err !== 1'b1) begin n_errors++; $display("FAIL to_err: got %b want 1", err); end
    n_checks++;
    if (obs_q.size() != 0 || n_done != 1 || busy !== 1'b0) begin
      n_errors++; $display("FAIL to_end: got beats=%0d done=%0d busy=%b want 0/1/0", obs_q.size(), n_done, busy);
    end
    ack_en = 1'b1;
  endtask

  task automatic test_zero_len();
    clr();
    @(posedge clk); #1;
    cfg_base_addr = 32'd0; cfg_len = 16'd0; cfg_start = 1'b1;
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_errors++; $display("FAIL zl_c0: got done=%b busy=%b want 0/0", done, busy);
    end
    @(posedge clk); #1; cfg_start = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
      n_errors++; $display("FAIL zl_c1: got busy=%b done=%b err=%b want 1/0/0", busy, done, err);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b1) begin n_errors++; $display("FAIL zl_c2_done: got %b want 1", done); end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || n_cyc != 0) begin
      n_errors++; $display("FAIL zl_c3: got done=%b busy=%b cyc_cycles=%0d want 0/0/0", done, busy, n_cyc);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [32:0] e, o;
    clr(); ack_delay = 3; ss_tready = 1'b0;
    start(32'h0000_0100, 16'd4);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (n_ack == 2 && wbm_cyc_o) begin ok = 1'b1; break; end
    end
    n_checks++;
    if (!ok || ss_tvalid !== 1'b1) begin
      n_errors++; $display("FAIL rm_setup: got reached=%b tvalid=%b want 1/1", ok, ss_tvalid);
    end
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({wbm_cyc_o, wbm_stb_o, ss_tvalid, busy} !== 4'b0) begin
      n_errors++; $display("FAIL rm_async: got cyc/stb/tvalid/busy=%b want 0000",
        {wbm_cyc_o, wbm_stb_o, ss_tvalid, busy});
    end
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || wbm_cyc_o !== 1'b0) begin
      n_errors++; $display("FAIL rm_idle: got busy=%b cyc=%b want 0/0", busy, wbm_cyc_o);
    end
    clr(); ack_delay = 1; ss_tready = 1'b1;
    push_exp(32'h0, 1);
    start(32'h0, 16'd1);
    wait_done(200, ok);
    n_checks++;
    if (!ok) begin n_errors++; $display("FAIL rm_done_timeout: got no done want done"); end
    repeat (3) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_errors++; $display("FAIL rm_beat: got none want %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin n_errors++; $display("FAIL rm_beat: got %h want %h", o, e); end
      end
    end
    n_checks++;
    if (obs_q.size() != 0 || n_done != 1) begin
      n_errors++; $display("FAIL rm_end: got extra=%0d done=%0d want 0/1", obs_q.size(), n_done);
    end
  endtask

  // second start is ignored; base near the top also exercises address wrap
  task automatic test_start_busy();
    bit ok;
    logic [32:0] e, o;
    clr(); ack_delay = 2; ss_tready = 1'b1;
    push_exp(32'hFFFF_FFF8, 4);
    start(32'hFFFF_FFF8, 16'd4);
    repeat (5) @(negedge clk);
    start(32'h5000_0000, 16'd2);
    wait_done(300, ok);
    n_checks++;
    if (!ok) begin n_errors++; $display("FAIL sb_done_timeout: got no done want done"); end
    repeat (6) @(negedge clk);
    n_checks++;
    if (n_ack != 4 || n_done != 1) begin
      n_errors++; $display("FAIL sb_counts: got acks=%0d done=%0d want 4/1", n_ack, n_done);
    end
    foreach (exp_adr[i]) if (i < adr_log.size()) begin
      n_checks++;
      if (adr_log[i] !== exp_adr[i]) begin
        n_errors++; $display("FAIL sb_addr[%0d]: got %h want %h", i, adr_log[i], exp_adr[i]);
      end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_errors++; $display("FAIL sb_beat: got none want %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin n_errors++; $display("FAIL sb_beat: got %h want %h", o, e); end
      end
    end
    n_checks++;
    if (obs_q.size() != 0 || busy !== 1'b0) begin
      n_errors++; $display("FAIL sb_end: got extra=%0d busy=%b want 0/0", obs_q.size(), busy);
    end
  endtask

  initial begin
    rst_n = 1'b0; cfg_start = 1'b0; cfg_base_addr = 32'd0; cfg_len = 16'd0; ss_tready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_timeout();
    test_zero_len();
    test_reset_mid();
    test_start_busy();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
